ibus_sram_responder: RTL and testbench

Instruction-bus responder: the memory-side end of the ibus_req_t/ibus_resp_t protocol driven by the fetch stage. It accepts one fetch request at a time, latches the address, waits a fixed programmable latency, then returns one 32-bit instruction word with a single-cycle data_ok pulse. It is backed by an internal word-addressed SRAM array, preloaded through a side write port, and serves as the simulation instruction memory behind fetch.

---
 rtl/ibus_sram_responder.sv | 113 +++++++++++
 tb/tb_ibus_sram_responder.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibus_sram_responder.sv
// Instruction-bus responder: fixed-latency SRAM-backed fetch memory with preload port.
// Optional macro IBUS_ABORT_EN: dropping ireq.valid while BUSY abandons the request.
module ibus_sram_responder #(
  parameter int          MEM_WORDS = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [64:0]                  ireq,
  output logic [33:0]                  iresp,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [31:0]                  load_data,
  output logic                         misalign_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam logic [3:0] CNT_INIT = 4'((LATENCY >= 2) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t         state, state_nxt;
  logic [3:0]     cnt, cnt_nxt;
  logic [63:0]    addr_q;
  logic [31:0]    data_q;
  logic           mis_q;
  logic [31:0]    mem [MEM_WORDS];

  logic           valid;
  logic [63:0]    req_addr;
  logic           accept;
  logic           abort;
  logic           enter_resp;
  logic [63:0]    rd_addr;
  logic [AW-1:0]  rd_idx;
  logic           misaligned;

  assign {valid, req_addr} = ireq;
  assign accept = valid && reset && (state == IDLE || state == RESP);

`ifdef IBUS_ABORT_EN
  assign abort = !valid;
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, RESP: begin
        if (accept) begin
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
          cnt_nxt   = CNT_INIT;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        // Abort takes priority even on the cycle the countdown expires.
        if (abort)
          state_nxt = IDLE;
        else if (cnt == '0)
          state_nxt = RESP;
        else
          cnt_nxt = cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // With LATENCY==1 RESP is entered on the accept edge itself, so the
  // incoming address is used before it lands in addr_q.
  assign enter_resp = (state_nxt == RESP);
  assign rd_addr    = accept ? req_addr : addr_q;
  assign rd_idx     = AW'((rd_addr - BASE_ADDR) >> 2);
  assign misaligned = (rd_addr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      mis_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      mis_q <= 1'b0;
      if (accept)
        addr_q <= req_addr;
      if (enter_resp) begin
        if (misaligned) begin
          data_q <= '0;
          mis_q  <= 1'b1;
        end else begin
          data_q <= mem[rd_idx];
        end
      end
    end
  end

  // Array is never reset; a same-edge write lands after the read above samples it.
  always_ff @(posedge clk) begin
    if (load_en && reset)
      mem[load_addr] <= load_data;
  end

  assign iresp        = {accept, (state == RESP), data_q};
  assign misalign_err = mis_q;

endmodule

// File: tb/tb_ibus_sram_responder.sv
// Directed bench: four responders (LATENCY 2,1,4,3) share clock and reset.
module tb_ibus_sram_responder;

  logic        clk;
  logic        rst_n;
  logic [64:0] ireq      [4];
  logic [33:0] iresp     [4];
  logic        load_en   [4];
  logic [9:0]  load_addr [4];
  logic [31:0] load_data [4];
  logic        mis       [4];

  int vectors;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 3;
    ibus_sram_responder #(
      .MEM_WORDS (1024),
      .LATENCY   (L),
      .BASE_ADDR (64'h8000_0000)
    ) dut (
      .clk          (clk),
      .reset        (rst_n),
      .ireq         (ireq[g]),
      .iresp        (iresp[g]),
      .load_en      (load_en[g]),
      .load_addr    (load_addr[g]),
      .load_data    (load_data[g]),
      .misalign_err (mis[g])
    );
  end

  // Instance index: 0 -> LAT2, 1 -> LAT1, 2 -> LAT4, 3 -> LAT3
  task automatic drive(input int i, input logic v, input logic [63:0] a);
    ireq[i] = {v, a};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      load_en[i] = 1'b1; load_addr[i] = 10'd0; load_data[i] = 32'h0000_0513;
      @(negedge clk);
      load_addr[i] = 10'd1; load_data[i] = 32'h0010_0593;
      @(negedge clk);
      load_en[i] = 1'b0;
    end
    drive(0, 1'b1, 64'h8000_0004);
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (iresp[i] !== 34'h0) begin
          errors++;
          $display("FAIL reset_iresp[%0d]: got %h want 0", i, iresp[i]);
        end
        vectors++;
        if (mis[i] !== 1'b0) begin
          errors++;
          $display("FAIL reset_mis[%0d]: got %b want 0", i, mis[i]);
        end
      end
    end
    drive(0, 1'b0, 64'h0);
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    @(negedge clk);
    drive(0, 1'b1, 64'h8000_0004);
    #1;
    vectors++;
    if (iresp[0][33] !== 1'b1) begin
      errors++; $display("FAIL single_addr_ok: got %b want 1", iresp[0][33]);
    end
    @(negedge clk);
    vectors++;
    if (iresp[0][33:32] !== 2'b00) begin
      errors++; $display("FAIL single_busy_flags: got %b want 00", iresp[0][33:32]);
    end
    @(negedge clk);
    drive(0, 1'b0, 64'h0);
    vectors++;
    if (iresp[0][32] !== 1'b1 || iresp[0][31:0] !== 32'h0010_0593 || mis[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got ok=%b data=%h mis=%b want 1 00100593 0",
               iresp[0][32], iresp[0][31:0], mis[0]);
    end
    @(negedge clk);
    vectors++;
    if (iresp[0][32] !== 1'b0 || iresp[0][31:0] !== 32'h0010_0593) begin
      errors++;
      $display("FAIL single_hold: got ok=%b data=%h want 0 00100593", iresp[0][32], iresp[0][31:0]);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive(1, 1'b1, 64'h8000_0000);
    #1;
    vectors++;
    if (iresp[1][33] !== 1'b1) begin
      errors++; $display("FAIL b2b_addr_ok0: got %b want 1", iresp[1][33]);
    end
    @(negedge clk);
    vectors++;
    if (iresp[1][32] !== 1'b1 || iresp[1][31:0] !== 32'h0000_0513) begin
      errors++;
      $display("FAIL b2b_first: got ok=%b data=%h want 1 00000513", iresp[1][32], iresp[1][31:0]);
    end
    drive(1, 1'b1, 64'h8000_0004);
    #1;
    vectors++;
    if (iresp[1][33] !== 1'b1) begin
      errors++; $display("FAIL b2b_addr_ok1: got %b want 1", iresp[1][33]);
    end
    @(negedge clk);
    vectors++;
    if (iresp[1][32] !== 1'b1 || iresp[1][31:0] !== 32'h0010_0593) begin
      errors++;
      $display("FAIL b2b_second: got ok=%b data=%h want 1 00100593", iresp[1][32], iresp[1][31:0]);
    end
    drive(1, 1'b0, 64'h0);
    @(negedge clk);
    vectors++;
    if (iresp[1][32] !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got ok=%b want 0", iresp[1][32]);
    end
  endtask

  task automatic test_misalign_alias();
    @(negedge clk);
    drive(1, 1'b1, 64'h8000_0002);
    @(negedge clk);
    vectors++;
    if (iresp[1][32] !== 1'b1 || iresp[1][31:0] !== 32'h0 || mis[1] !== 1'b1) begin
      errors++;
      $display("FAIL misalign: got ok=%b data=%h mis=%b want 1 00000000 1",
               iresp[1][32], iresp[1][31:0], mis[1]);
    end
    drive(1, 1'b1, 64'h8000_1000);
    @(negedge clk);
    vectors++;
    if (iresp[1][32] !== 1'b1 || iresp[1][31:0] !== 32'h0000_0513 || mis[1] !== 1'b0) begin
      errors++;
      $display("FAIL alias: got ok=%b data=%h mis=%b want 1 00000513 0",
               iresp[1][32], iresp[1][31:0], mis[1]);
    end
    drive(1, 1'b0, 64'h0);
    @(negedge clk);
    vectors++;
    if (iresp[1][32] !== 1'b0 || mis[1] !== 1'b0) begin
      errors++; $display("FAIL misalign_clear: got ok=%b mis=%b want 0 0", iresp[1][32], mis[1]);
    end
  endtask

  task automatic test_busy_addr_change();
    @(negedge clk);
    drive(2, 1'b1, 64'h8000_0000);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      drive(2, 1'b1, 64'h8000_0004);
      #1;
      vectors++;
      if (iresp[2][33:32] !== 2'b00) begin
        errors++;
        $display("FAIL busy_flags_c%0d: got %b want 00", c, iresp[2][33:32]);
      end
    end
    @(negedge clk);
    vectors++;
    if (iresp[2][32] !== 1'b1 || iresp[2][31:0] !== 32'h0000_0513) begin
      errors++;
      $display("FAIL busy_latched: got ok=%b data=%h want 1 00000513", iresp[2][32], iresp[2][31:0]);
    end
    drive(2, 1'b0, 64'h0);
  endtask

  task automatic test_collision();
    @(negedge clk);
    drive(0, 1'b1, 64'h8000_0000);
    @(negedge clk);
    load_en[0] = 1'b1; load_addr[0] = 10'd0; load_data[0] = 32'hDEAD_BEEF;
    @(negedge clk);
    load_en[0] = 1'b0;
    drive(0, 1'b0, 64'h0);
    vectors++;
    if (iresp[0][32] !== 1'b1 || iresp[0][31:0] !== 32'h0000_0513) begin
      errors++;
      $display("FAIL collision_old: got ok=%b data=%h want 1 00000513", iresp[0][32], iresp[0][31:0]);
    end
    @(negedge clk);
    drive(0, 1'b1, 64'h8000_0000);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 64'h0);
    vectors++;
    if (iresp[0][32] !== 1'b1 || iresp[0][31:0] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL collision_new: got ok=%b data=%h want 1 deadbeef", iresp[0][32], iresp[0][31:0]);
    end
  endtask

  task automatic test_reset_busy();
    int pulses;
    @(negedge clk);
    drive(2, 1'b1, 64'h8000_0004);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (iresp[2] !== 34'h0 || mis[2] !== 1'b0) begin
      errors++; $display("FAIL reset_busy_outputs: got %h mis=%b want 0 0", iresp[2], mis[2]);
    end
    @(negedge clk);
    drive(2, 1'b0, 64'h0);
    rst_n = 1'b1;
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (iresp[2][32] === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      errors++; $display("FAIL reset_busy_no_ok: got %0d pulses want 0", pulses);
    end
    drive(2, 1'b1, 64'h8000_0004);
    repeat (3) @(negedge clk);
    @(negedge clk);
    drive(2, 1'b0, 64'h0);
    vectors++;
    if (iresp[2][32] !== 1'b1 || iresp[2][31:0] !== 32'h0010_0593) begin
      errors++;
      $display("FAIL reset_retained: got ok=%b data=%h want 1 00100593", iresp[2][32], iresp[2][31:0]);
    end
  endtask

  task automatic test_abort();
    int pulses;
    @(negedge clk);
    drive(3, 1'b1, 64'h8000_0004);
    @(negedge clk);
    drive(3, 1'b0, 64'h0);
`ifdef IBUS_ABORT_EN
    @(negedge clk);
    vectors++;
    if (iresp[3][32] !== 1'b0) begin
      errors++; $display("FAIL abort_no_ok: got %b want 0", iresp[3][32]);
    end
    drive(3, 1'b1, 64'h8000_0000);
    #1;
    vectors++;
    if (iresp[3][33] !== 1'b1) begin
      errors++; $display("FAIL abort_reaccept: got addr_ok=%b want 1", iresp[3][33]);
    end
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (iresp[3][32] === 1'b1) pulses++;
    end
    vectors++;
    if (pulses !== 0) begin
      errors++; $display("FAIL abort_early_ok: got %0d pulses want 0", pulses);
    end
    @(negedge clk);
    drive(3, 1'b0, 64'h0);
    vectors++;
    if (iresp[3][32] !== 1'b1 || iresp[3][31:0] !== 32'h0000_0513) begin
      errors++;
      $display("FAIL abort_next: got ok=%b data=%h want 1 00000513", iresp[3][32], iresp[3][31:0]);
    end
`else
    pulses = 0;
    repeat (5) begin
      @(negedge clk);
      if (iresp[3][32] === 1'b1) begin
        pulses++;
        vectors++;
        if (iresp[3][31:0] !== 32'h0010_0593) begin
          errors++; $display("FAIL noabort_data: got %h want 00100593", iresp[3][31:0]);
        end
      end
    end
    vectors++;
    if (pulses !== 1) begin
      errors++; $display("FAIL noabort_pulses: got %0d want 1", pulses);
    end
`endif
  endtask

  initial begin
    vectors = 0;
    errors  = 0;
    rst_n   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ireq[i]      = '0;
      load_en[i]   = 1'b0;
      load_addr[i] = '0;
      load_data[i] = '0;
    end
    test_reset();
    test_single_read();
    test_back_to_back();
    test_misalign_alias();
    test_busy_addr_change();
    test_collision();
    test_reset_busy();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
